// File: rtl/segment_cfg_bank.sv
// segment_cfg_bank: double-buffered per-segment config bank; CPU writes shadow, a CTL set bit commits shadow->active
// and raises UPDATE until the consumer acks. Optional shadow readback is built when SEGMENT_CFG_READBACK_EN is defined.
module segment_cfg_bank #(
  parameter int          NUM_SEGMENTS     = 2,
  parameter logic [7:0]  BASE_ADDR        = 8'h20,
  parameter logic [7:0]  CTL_ADDR         = 8'h00,
  parameter int          SET_BIT          = 0,
  parameter logic [31:0] DEFAULT_FREQ_DIV = 32'd10,
  localparam int         SEG_W            = $clog2(NUM_SEGMENTS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cpu_we_i,
  input  logic [7:0]                cpu_addr_i,
  input  logic [15:0]               cpu_din_i,
  input  logic [7:0]                cpu_rd_addr_i,
  output logic [15:0]               cpu_dout_o,
  output logic [SEG_W-1:0]          req_seg_o,
  output logic [NUM_SEGMENTS*16-1:0] cycle_o,
  output logic [NUM_SEGMENTS*32-1:0] freq_div_o,
  output logic [NUM_SEGMENTS*16-1:0] rep_o,
  output logic [SEG_W-1:0]          wr_seg_o,
  output logic                      update_o,
  input  logic                      update_ack_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int MAP_WORDS = 2 + 4 * NUM_SEGMENTS;
  localparam logic [SEG_W-1:0] LAST_IDX = SEG_W'(NUM_SEGMENTS - 1);

  if ((NUM_SEGMENTS < 2) || (32'(BASE_ADDR) + 32'(MAP_WORDS) > 32'd256)) begin : g_bad_params
    $error("segment_cfg_bank: NUM_SEGMENTS < 2 or register map exceeds 8-bit address space");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_NOTIFY = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SEG_W-1:0]  idx_q, idx_d;
  logic              pending_q, pending_d;
  logic              err_q, err_d;
  logic              update_q, update_d;
  logic              busy_q, busy_d;

  logic [7:0]  wr_seg_sh_q;
  logic [7:0]  req_rd_sh_q;
  logic [15:0] cyc_sh_q    [NUM_SEGMENTS];
  logic [15:0] div_lo_sh_q [NUM_SEGMENTS];
  logic [15:0] div_hi_sh_q [NUM_SEGMENTS];
  logic [15:0] rep_sh_q    [NUM_SEGMENTS];

  logic [15:0]      cyc_act_q [NUM_SEGMENTS];
  logic [31:0]      div_act_q [NUM_SEGMENTS];
  logic [15:0]      rep_act_q [NUM_SEGMENTS];
  logic [SEG_W-1:0] req_seg_q;

  logic [8:0] off_s;
  logic [8:0] rel_s;
  logic [6:0] seg_sel_s;
  logic [1:0] fld_s;
  logic       in_map_s;
  logic       set_s;

  // Addresses below BASE_ADDR wrap to >= 256 in 9 bits, so one compare covers both ends of the map.
  assign off_s     = {1'b0, cpu_addr_i} - {1'b0, BASE_ADDR};
  assign rel_s     = off_s - 9'd2;
  assign seg_sel_s = rel_s[8:2];
  assign fld_s     = rel_s[1:0];
  assign in_map_s  = (off_s < 9'(MAP_WORDS));
  assign set_s     = cpu_we_i && (cpu_addr_i == CTL_ADDR) && cpu_din_i[SET_BIT];

  // Shadow register writes from the CPU port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_seg_sh_q <= 8'h00;
      req_rd_sh_q <= 8'h00;
      for (int s = 0; s < NUM_SEGMENTS; s++) begin
        cyc_sh_q[s]    <= 16'h0000;
        div_lo_sh_q[s] <= DEFAULT_FREQ_DIV[15:0];
        div_hi_sh_q[s] <= DEFAULT_FREQ_DIV[31:16];
        rep_sh_q[s]    <= 16'h0000;
      end
    end else if (cpu_we_i && in_map_s) begin
      if (off_s == 9'd0) begin
        wr_seg_sh_q <= cpu_din_i[7:0];
      end else if (off_s == 9'd1) begin
        req_rd_sh_q <= cpu_din_i[7:0];
      end else begin
        for (int s = 0; s < NUM_SEGMENTS; s++) begin
          if (seg_sel_s == 7'(s)) begin
            case (fld_s)
              2'd0:    cyc_sh_q[s]    <= cpu_din_i;
              2'd1:    div_lo_sh_q[s] <= cpu_din_i;
              2'd2:    div_hi_sh_q[s] <= cpu_din_i;
              default: rep_sh_q[s]    <= cpu_din_i;
            endcase
          end
        end
      end
    end
  end

  // Active set: one segment copied per COMMIT cycle; a same-cycle shadow write is seen by the next commit only
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_seg_q <= {SEG_W{1'b0}};
      for (int s = 0; s < NUM_SEGMENTS; s++) begin
        cyc_act_q[s] <= 16'h0000;
        div_act_q[s] <= DEFAULT_FREQ_DIV;
        rep_act_q[s] <= 16'h0000;
      end
    end else if (state_q == ST_COMMIT) begin
      for (int s = 0; s < NUM_SEGMENTS; s++) begin
        if (idx_q == SEG_W'(s)) begin
          cyc_act_q[s] <= cyc_sh_q[s];
          div_act_q[s] <= {div_hi_sh_q[s], div_lo_sh_q[s]};
          rep_act_q[s] <= rep_sh_q[s];
        end
      end
      if (idx_q == LAST_IDX) begin
        req_seg_q <= req_rd_sh_q[SEG_W-1:0];
      end
    end
  end

  // Commit sequencer next-state; sets arriving while busy collapse into one pending request
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    pending_d = pending_q | (set_s & (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (set_s || pending_q) begin
          state_d   = ST_CHECK;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (req_rd_sh_q >= 8'(NUM_SEGMENTS)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          err_d   = 1'b0;
          state_d = ST_COMMIT;
          idx_d   = {SEG_W{1'b0}};
        end
      end
      ST_COMMIT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_NOTIFY;
          idx_d   = {SEG_W{1'b0}};
        end else begin
          idx_d = idx_q + SEG_W'(1);
        end
      end
      ST_NOTIFY: begin
        if (update_ack_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_NOTIFY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    update_d = (state_d == ST_NOTIFY);
    busy_d   = (state_d != ST_IDLE);
  end

  // Sequencer state and registered handshake/status flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= {SEG_W{1'b0}};
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      update_q  <= update_d;
      busy_q    <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_SEGMENTS; g++) begin : g_pack
    assign cycle_o[16*g +: 16]    = cyc_act_q[g];
    assign freq_div_o[32*g +: 32] = div_act_q[g];
    assign rep_o[16*g +: 16]      = rep_act_q[g];
  end

  assign req_seg_o = req_seg_q;
  assign wr_seg_o  = wr_seg_sh_q[SEG_W-1:0];
  assign update_o  = update_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

`ifdef SEGMENT_CFG_READBACK_EN
  logic [8:0]  rd_off_s;
  logic [8:0]  rd_rel_s;
  logic [15:0] rd_data_s;
  logic [15:0] dout_q;
  logic        unused_s;

  assign rd_off_s = {1'b0, cpu_rd_addr_i} - {1'b0, BASE_ADDR};
  assign rd_rel_s = rd_off_s - 9'd2;
  assign unused_s = ^wr_seg_sh_q;

  // Shadow readback mux
  always_comb begin
    rd_data_s = 16'h0000;
    if (rd_off_s == 9'd0) begin
      rd_data_s = {8'h00, wr_seg_sh_q};
    end else if (rd_off_s == 9'd1) begin
      rd_data_s = {8'h00, req_rd_sh_q};
    end else if (rd_off_s < 9'(MAP_WORDS)) begin
      for (int s = 0; s < NUM_SEGMENTS; s++) begin
        if (rd_rel_s[8:2] == 7'(s)) begin
          case (rd_rel_s[1:0])
            2'd0:    rd_data_s = cyc_sh_q[s];
            2'd1:    rd_data_s = div_lo_sh_q[s];
            2'd2:    rd_data_s = div_hi_sh_q[s];
            default: rd_data_s = rep_sh_q[s];
          endcase
        end else begin
          rd_data_s = rd_data_s;
        end
      end
    end else begin
      rd_data_s = 16'h0000;
    end
  end

  // One-cycle registered readback
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout_q <= 16'h0000;
    end else begin
      dout_q <= rd_data_s;
    end
  end

  assign cpu_dout_o = dout_q;
`else
  logic unused_s;
  assign unused_s   = ^{cpu_rd_addr_i, wr_seg_sh_q};
  assign cpu_dout_o = 16'h0000;
`endif

endmodule

// File: tb/tb_segment_cfg_bank.sv
// Directed bench for segment_cfg_bank (N=2): scoreboard of expected active sets pushed on each set, popped on UPDATE.
module tb_segment_cfg_bank;
  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_addr = 8'h00;
  logic [15:0] cpu_din = 16'h0000;
  logic [7:0]  cpu_rd_addr = 8'h00;
  logic        ack = 1'b0;
  logic [15:0] cpu_dout;
  logic        req_seg;
  logic [31:0] cycle;
  logic [63:0] freq_div;
  logic [31:0] rep;
  logic        wr_seg;
  logic        update;
  logic        busy;
  logic        err;

  segment_cfg_bank #(.NUM_SEGMENTS(N)) dut (
    .clk_i(clk), .rst_i(rst), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
    .cpu_rd_addr_i(cpu_rd_addr), .cpu_dout_o(cpu_dout), .req_seg_o(req_seg), .cycle_o(cycle),
    .freq_div_o(freq_div), .rep_o(rep), .wr_seg_o(wr_seg), .update_o(update),
    .update_ack_i(ack), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [63:0] div;
    logic [31:0] rep;
    logic        req;
  } snap_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  snap_t sb[$];
  snap_t act;
  snap_t exp_s;
  snap_t reset_snap;
  int    n;
  int    highs;

  logic [15:0] m_cyc [N];
  logic [15:0] m_lo  [N];
  logic [15:0] m_hi  [N];
  logic [15:0] m_rep [N];
  logic [7:0]  m_req;
  logic [7:0]  m_wr;

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < N; s++) begin
      m_cyc[s] = 16'h0000; m_lo[s] = 16'd10; m_hi[s] = 16'h0000; m_rep[s] = 16'h0000;
    end
    m_req = 8'h00;
    m_wr  = 8'h00;
  endtask

  function automatic snap_t model_snap();
    snap_t r;
    r.cyc = {m_cyc[1], m_cyc[0]};
    r.div = {m_hi[1], m_lo[1], m_hi[0], m_lo[0]};
    r.rep = {m_rep[1], m_rep[0]};
    r.req = m_req[0];
    return r;
  endfunction

  // Map for BASE 0x20: +0 WR_SEG, +1 REQ_RD, seg s at +2+4s: CYCLE, DIV_LO, DIV_HI, REP.
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    int off;
    cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    tick(1);
    cpu_we = 1'b0;
    off = int'(a) - 32;
    if (off == 0) m_wr = d[7:0];
    else if (off == 1) m_req = d[7:0];
    else if (off >= 2 && off < 2 + 4 * N) begin
      case ((off - 2) % 4)
        0: m_cyc[(off - 2) / 4] = d;
        1: m_lo[(off - 2) / 4]  = d;
        2: m_hi[(off - 2) / 4]  = d;
        default: m_rep[(off - 2) / 4] = d;
      endcase
    end
  endtask

  task automatic set_commit();
    wr(8'h00, 16'h0001);
  endtask

  task automatic chk_out(input string tag, input snap_t e);
    chk({tag, ".cycle"}, {32'h0, cycle}, {32'h0, e.cyc});
    chk({tag, ".freq_div"}, freq_div, e.div);
    chk({tag, ".rep"}, {32'h0, rep}, {32'h0, e.rep});
    chk({tag, ".req_seg"}, {63'h0, req_seg}, {63'h0, e.req});
  endtask

  // n counts cycles after the set edge (first sample is 1); bounded at 64
  task automatic wait_sig(input bit use_err, output int cnt);
    cnt = 1;
    while (((use_err ? err : update) !== 1'b1) && cnt < 64) begin
      tick(1);
      cnt++;
    end
  endtask

  task automatic pop_chk(input string tag);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp_s = sb.pop_front();
      chk_out(tag, exp_s);
      act = exp_s;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    model_reset();
    reset_snap = model_snap();
    tick(3);
    rst = 1'b0;
    tick(1);

    chk_out("reset", reset_snap);
    chk("reset.update", {63'h0, update}, 64'd0);
    chk("reset.busy", {63'h0, busy}, 64'd0);
    chk("reset.err", {63'h0, err}, 64'd0);
    chk("reset.dout", {48'h0, cpu_dout}, 64'd0);
    chk("reset.wr_seg", {63'h0, wr_seg}, 64'd0);
    act = reset_snap;

    wr(8'h20, 16'h0001);
    chk("wr_seg.shadow", {63'h0, wr_seg}, 64'd1);
    wr(8'h26, 16'h00FF);
    wr(8'h27, 16'h0000);
    wr(8'h28, 16'h0001);
    wr(8'h29, 16'h0003);
    wr(8'h21, 16'h0001);
    chk_out("shadow_only", act);
    set_commit();
    sb.push_back(model_snap());
    chk("commit1.busy_check", {63'h0, busy}, 64'd1);
    wait_sig(1'b0, n);
    chk("commit1.latency", 64'(n), 64'(N + 2));
    pop_chk("commit1");
    chk("commit1.cycle_seg1", {48'h0, cycle[31:16]}, 64'h00FF);
    do_ack();
    chk("commit1.update_drop", {63'h0, update}, 64'd0);
    chk("commit1.busy_drop", {63'h0, busy}, 64'd0);

    wr(8'h21, 16'h0005);
    wr(8'h22, 16'h4444);
    set_commit();
    wait_sig(1'b1, n);
    chk("err.latency", 64'(n), 64'd2);
    chk("err.busy", {63'h0, busy}, 64'd0);
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      if (update === 1'b1) highs++;
      tick(1);
    end
    chk("err.no_update", 64'(highs), 64'd0);
    chk_out("err.hold", act);
    chk("err.sticky", {63'h0, err}, 64'd1);

    wr(8'h21, 16'h0000);
    wr(8'h22, 16'h1234);
    wr(8'h2A, 16'h7777);
    wr(8'h1F, 16'h7777);
    set_commit();
    sb.push_back(model_snap());
    wait_sig(1'b0, n);
    chk("commit2.latency", 64'(n), 64'(N + 2));
    chk("commit2.err_clear", {63'h0, err}, 64'd0);
    pop_chk("commit2");
    do_ack();

    ack = 1'b1;
    tick(2);
    ack = 1'b0;
    chk("idle_ack.update", {63'h0, update}, 64'd0);
    chk("idle_ack.busy", {63'h0, busy}, 64'd0);

    wr(8'h25, 16'hFFFF);
    set_commit();
    sb.push_back(model_snap());
    wait_sig(1'b0, n);
    pop_chk("pend.first");
    tick(9);
    chk("pend.hold_a", {63'h0, update}, 64'd1);
    wr(8'h26, 16'hAAAA);
    set_commit();
    sb.push_back(model_snap());
    chk_out("pend.outputs_frozen", act);
    chk("pend.busy", {63'h0, busy}, 64'd1);
    tick(8);
    chk("pend.hold_b", {63'h0, update}, 64'd1);
    do_ack();
    chk("pend.update_drop", {63'h0, update}, 64'd0);
    chk("pend.idle_gap", {63'h0, busy}, 64'd0);
    wait_sig(1'b0, n);
    chk("pend.second_latency", 64'(n), 64'(N + 3));
    pop_chk("pend.second");
    do_ack();
    chk("pend.done", {63'h0, busy}, 64'd0);

    wr(8'h22, 16'h5555);
    set_commit();
    tick(1);
    rst = 1'b1;
    #1;
    chk_out("rst_commit", reset_snap);
    chk("rst_commit.update", {63'h0, update}, 64'd0);
    chk("rst_commit.busy", {63'h0, busy}, 64'd0);
    model_reset();
    tick(1);
    rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (update === 1'b1 || busy === 1'b1) highs++;
    end
    chk("rst_commit.no_update", 64'(highs), 64'd0);

    wr(8'h23, 16'hBEEF);
    wr(8'h21, 16'h0301);
    cpu_rd_addr = 8'h23;
    tick(1);
`ifdef SEGMENT_CFG_READBACK_EN
    chk("rb.div_lo", {48'h0, cpu_dout}, 64'hBEEF);
`else
    chk("rb.div_lo", {48'h0, cpu_dout}, 64'h0);
`endif
    cpu_rd_addr = 8'h21;
    tick(1);
`ifdef SEGMENT_CFG_READBACK_EN
    chk("rb.req_rd", {48'h0, cpu_dout}, 64'h0001);
`else
    chk("rb.req_rd", {48'h0, cpu_dout}, 64'h0);
`endif
    cpu_rd_addr = 8'h2A;
    tick(1);
    chk("rb.unmapped", {48'h0, cpu_dout}, 64'h0);

    set_commit();
    sb.push_back(model_snap());
    wait_sig(1'b0, n);
    chk("commit3.latency", 64'(n), 64'(N + 2));
    pop_chk("commit3");
    chk("commit3.div_lo_seg0", {32'h0, freq_div[31:0]}, 64'h0000_BEEF);
    do_ack();
    chk("sb.drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
